data_demux: RTL and testbench

DATA_DEMUX -- requirements
Module: data_demux

---
 rtl/data_demux_if.sv | 19 +
 rtl/data_demux.sv | 119 +++++++++++
 tb/tb_data_demux.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_demux_if.sv
// Ingress/egress FIFO bundle for data_demux: one FWFT ingress stream in,
// six channel FIFOs sharing one data bus out.
interface data_demux_if;
    logic [15:0] ingress_fifo_out;
    logic        ingress_fifo_empty;
    logic        ingress_fifo_rd_en;
    logic [15:0] egress_fifo_din;
    logic [5:0]  egress_fifo_wren;
    logic [5:0]  egress_fifo_full;

    modport slave (
        input  ingress_fifo_out, ingress_fifo_empty, egress_fifo_full,
        output ingress_fifo_rd_en, egress_fifo_din, egress_fifo_wren
    );
    modport master (
        output ingress_fifo_out, ingress_fifo_empty, egress_fifo_full,
        input  ingress_fifo_rd_en, egress_fifo_din, egress_fifo_wren
    );
endinterface

// File: rtl/data_demux.sv
// Packet demultiplexer: parses header/length/payload/trailer framing from one
// ingress stream and steers payload words to one of six channel FIFOs.
module data_demux #(
    parameter logic [7:0]  HEADER_TAG   = 8'hA5,
    parameter logic [15:0] TRAILER_WORD = 16'h5A5A,
    parameter logic [15:0] MAX_LEN      = 16'd1024
) (
    input  logic        init_clk,
    input  logic        reset_n_i,
    input  logic [5:0]  ch_en,
    data_demux_if.slave fifo_if,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt,
    output logic        busy
);
    typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, TRAILER} state_e;

    state_e      state_q, state_d;
    logic [15:0] rem_q, rem_d;
    logic [2:0]  ch_q, ch_d;
    logic        en_q, en_d;
    logic [15:0] pkt_q, pkt_d;
    logic [15:0] err_q, err_d;

    logic [15:0] word;
    logic        avail;
    logic        pop;
    logic [5:0]  wren;
    logic        pkt_inc;
    logic        err_inc;

    assign word = fifo_if.ingress_fifo_out;
    // Gating with reset keeps the strobes quiet while reset is held, not just after the next edge.
    assign avail = !fifo_if.ingress_fifo_empty && reset_n_i;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ch_d    = ch_q;
        en_d    = en_q;
        pop     = 1'b0;
        wren    = 6'd0;
        pkt_inc = 1'b0;
        err_inc = 1'b0;
        case (state_q)
            HUNT: begin
                if (avail) begin
                    pop = 1'b1;
                    if (word[15:8] == HEADER_TAG && word[7:3] == 5'd0 && word[2:0] <= 3'd5) begin
                        ch_d    = word[2:0];
                        en_d    = ch_en[word[2:0]];
                        state_d = LEN;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            LEN: begin
                if (avail) begin
                    pop = 1'b1;
                    if (word == 16'd0) begin
                        state_d = TRAILER;
                    end else if (word <= MAX_LEN) begin
                        rem_d   = word;
                        state_d = PAYLOAD;
                    end else begin
                        err_inc = 1'b1;
                        state_d = HUNT;
                    end
                end
            end
            PAYLOAD: begin
                // A dropped packet never stalls on the full flag of its channel.
                if (avail && (!en_q || !fifo_if.egress_fifo_full[ch_q])) begin
                    pop   = 1'b1;
                    rem_d = rem_q - 16'd1;
                    if (en_q) wren = 6'b000001 << ch_q;
                    if (rem_q == 16'd1) state_d = TRAILER;
                end
            end
            TRAILER: begin
                if (avail) begin
                    pop     = 1'b1;
                    state_d = HUNT;
                    if (word == TRAILER_WORD) pkt_inc = 1'b1;
                    else                      err_inc = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
        pkt_d = (pkt_inc && pkt_q != 16'hFFFF) ? pkt_q + 16'd1 : pkt_q;
        err_d = (err_inc && err_q != 16'hFFFF) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge init_clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= HUNT;
            rem_q   <= 16'd0;
            ch_q    <= 3'd0;
            en_q    <= 1'b0;
            pkt_q   <= 16'd0;
            err_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            ch_q    <= ch_d;
            en_q    <= en_d;
            pkt_q   <= pkt_d;
            err_q   <= err_d;
        end
    end

    assign fifo_if.ingress_fifo_rd_en = pop;
    assign fifo_if.egress_fifo_wren   = wren;
    assign fifo_if.egress_fifo_din    = word;
    assign pkt_cnt = pkt_q;
    assign err_cnt = err_q;
    assign busy    = (state_q != HUNT);
endmodule

// File: tb/tb_data_demux.sv
// Directed bench for data_demux: a queue-backed FWFT ingress model feeds the
// DUT and observed channel writes are matched against an expected-write scoreboard.
module tb_data_demux;
    logic        init_clk  = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [5:0]  ch_en     = 6'h3F;
    logic [15:0] pkt_cnt, err_cnt;
    logic        busy;

    data_demux_if bus();

    data_demux dut (
        .init_clk  (init_clk),
        .reset_n_i (reset_n_i),
        .ch_en     (ch_en),
        .fifo_if   (bus),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    typedef struct packed {logic [5:0] wren; logic [15:0] din;} wr_t;

    logic [15:0] in_q[$];
    wr_t         exp_q[$];
    wr_t         obs_q[$];
    int          pop_cnt = 0;
    int          bad_oh  = 0;
    int          checks  = 0;
    int          errors  = 0;

    always #5 init_clk = ~init_clk;

    // Ingress FIFO view changes only on the falling edge, away from DUT sampling.
    initial begin
        bus.ingress_fifo_empty = 1'b1;
        bus.ingress_fifo_out   = 16'h0;
        forever begin
            @(negedge init_clk);
            bus.ingress_fifo_empty = (in_q.size() == 0);
            bus.ingress_fifo_out   = (in_q.size() != 0) ? in_q[0] : 16'h0;
        end
    end

    always @(posedge init_clk) begin
        if (bus.ingress_fifo_rd_en) begin
            pop_cnt++;
            if (in_q.size() != 0) void'(in_q.pop_front());
        end
        if (bus.egress_fifo_wren != 6'd0) begin
            obs_q.push_back({bus.egress_fifo_wren, bus.egress_fifo_din});
            if (!$onehot(bus.egress_fifo_wren)) bad_oh++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge init_clk);
    endtask

    task automatic send(input logic [15:0] w);
        in_q.push_back(w);
    endtask

    task automatic exp_wr(input int ch, input logic [15:0] d);
        wr_t e;
        e.wren = 6'd0;
        e.wren[ch] = 1'b1;
        e.din = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        int n = 0;
        bit idle = 1'b0;
        while (!idle && n < max_cyc) begin
            @(negedge init_clk);
            #1;
            idle = (in_q.size() == 0) && !busy;
            n++;
        end
        chk(tag, 32'(idle), 32'd1);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwr"}, obs_q.size(), exp_q.size());
        while (obs_q.size() != 0 && exp_q.size() != 0)
            chk(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int base;
        int n;
        bus.egress_fifo_full = 6'd0;

        // Reset state
        cyc(3);
        #1;
        chk("rst_pkt", pkt_cnt, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rd", bus.ingress_fifo_rd_en, 0);
        chk("rst_wren", bus.egress_fifo_wren, 0);
        reset_n_i = 1'b1;
        cyc(2);

        // Basic packet to channel 2
        send(16'hA502); send(16'h0003);
        send(16'h1111); exp_wr(2, 16'h1111);
        send(16'h2222); exp_wr(2, 16'h2222);
        send(16'h3333); exp_wr(2, 16'h3333);
        send(16'h5A5A);
        wait_idle("t1_idle", 50);
        check_writes("t1_wr");
        chk("t1_pkt", pkt_cnt, 1);
        chk("t1_err", err_cnt, 0);

        // Full stall in payload
        bus.egress_fifo_full = 6'b000100;
        base = pop_cnt;
        send(16'hA502); send(16'h0003);
        send(16'h1111); exp_wr(2, 16'h1111);
        send(16'h2222); exp_wr(2, 16'h2222);
        send(16'h3333); exp_wr(2, 16'h3333);
        send(16'h5A5A);
        cyc(6);
        cyc(10);
        chk("stall_pops", pop_cnt - base, 2);
        chk("stall_wr", obs_q.size(), 0);
        chk("stall_busy", busy, 1);
        bus.egress_fifo_full = 6'd0;
        wait_idle("t2_idle", 50);
        check_writes("t2_wr");
        chk("t2_pkt", pkt_cnt, 2);

        // Disabled channel: consumed, dropped, still counted
        ch_en = 6'h3B;
        base = pop_cnt;
        send(16'hA502); send(16'h0003);
        send(16'h1111); send(16'h2222); send(16'h3333); send(16'h5A5A);
        wait_idle("t3_idle", 50);
        ch_en = 6'h3F;
        chk("t3_pops", pop_cnt - base, 6);
        check_writes("t3_wr");
        chk("t3_pkt", pkt_cnt, 3);
        chk("t3_err", err_cnt, 0);

        // Garbage then zero-length packet
        send(16'h1234); send(16'hA501); send(16'h0000); send(16'h5A5A);
        wait_idle("t4_idle", 50);
        check_writes("t4_wr");
        chk("t4_err", err_cnt, 1);
        chk("t4_pkt", pkt_cnt, 4);

        // Length over MAX_LEN, bad trailer, channel 6, nonzero reserved bits
        send(16'hA500); send(16'h0401);
        wait_idle("t5a_idle", 50);
        chk("t5_len_err", err_cnt, 2);
        send(16'hA500); send(16'h0000); send(16'h0000);
        wait_idle("t5b_idle", 50);
        chk("t5_trl_err", err_cnt, 3);
        send(16'hA506);
        wait_idle("t5c_idle", 50);
        chk("t5_ch6_err", err_cnt, 4);
        send(16'hA50D);
        wait_idle("t5d_idle", 50);
        chk("t5_rsv_err", err_cnt, 5);
        check_writes("t5_wr");
        chk("t5_pkt", pkt_cnt, 4);

        // Exactly MAX_LEN payload words on channel 5
        send(16'hA505); send(16'h0400);
        for (int i = 0; i < 1024; i++) begin
            send(16'(i * 7 + 3));
            exp_wr(5, 16'(i * 7 + 3));
        end
        send(16'h5A5A);
        wait_idle("t6_idle", 2000);
        check_writes("t6_wr");
        chk("t6_pkt", pkt_cnt, 5);
        chk("t6_err", err_cnt, 5);

        // Reset after the second payload word
        send(16'hA502); send(16'h0003);
        send(16'h1111); exp_wr(2, 16'h1111);
        send(16'h2222); exp_wr(2, 16'h2222);
        send(16'h3333); send(16'h5A5A);
        n = 0;
        while (obs_q.size() < 2 && n < 50) begin
            @(negedge init_clk);
            n++;
        end
        chk("t7_reach", obs_q.size(), 2);
        reset_n_i = 1'b0;
        #1;
        chk("t7_rd", bus.ingress_fifo_rd_en, 0);
        chk("t7_wren", bus.egress_fifo_wren, 0);
        chk("t7_busy", busy, 0);
        chk("t7_pkt", pkt_cnt, 0);
        chk("t7_err", err_cnt, 0);
        in_q.delete();
        cyc(3);
        reset_n_i = 1'b1;
        cyc(3);
        check_writes("t7_wr");
        send(16'hA501); send(16'h0002);
        send(16'hAAAA); exp_wr(1, 16'hAAAA);
        send(16'hBBBB); exp_wr(1, 16'hBBBB);
        send(16'h5A5A);
        wait_idle("t8_idle", 50);
        check_writes("t8_wr");
        chk("t8_pkt", pkt_cnt, 1);
        chk("t8_err", err_cnt, 0);
        chk("onehot", bad_oh, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
